// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave cook-sequence controller.
package microwave_pkg;

  localparam int DIGIT_W  = 4;
  localparam int NUM_KEYS = 10;

  // Encoding is visible on the state port, so values are fixed explicitly.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_COOK  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // One-hot key vector to BCD digit. Only meaningful for a one-hot input;
  // callers qualify the result with a one-hot test.
  function automatic logic [DIGIT_W-1:0] onehot_to_bcd(input logic [NUM_KEYS-1:0] keys);
    logic [DIGIT_W-1:0] digit;
    digit = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) digit = digit | DIGIT_W'(i);
    end
    return digit;
  endfunction

endpackage

// File: rtl/mw_tick_div.sv
// Free-running divider producing one pulse every TICK_DIV enabled cycles.
// o_wrap is the combinational "last count" strobe; o_tick is its registered copy.
module mw_tick_div #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic clrn,
  input  logic i_restart,
  input  logic i_en,
  output logic o_wrap,
  output logic o_tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_tick;

  // A restart in the same cycle as a would-be wrap takes precedence.
  assign o_wrap = i_en & ~i_restart & (r_cnt == CNT_W'(TICK_DIV - 1));
  assign o_tick = r_tick;

  // Count 0..TICK_DIV-1 while enabled; hold when disabled; restart to zero.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_restart) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (i_en) begin
      r_cnt  <= o_wrap ? '0 : r_cnt + CNT_W'(1);
      r_tick <= o_wrap;
    end else begin
      r_tick <= 1'b0;
    end
  end

endmodule

// File: rtl/microwave_cook_ctrl.sv
// Cook-sequence controller: keypad entry into the BCD timer, start/pause/stop
// of the countdown, 1 Hz tick generation, magnetron gating and end-of-cook beep.
module microwave_cook_ctrl
  import microwave_pkg::*;
#(
  parameter int TICK_DIV        = 50_000_000,
  parameter int MAX_DIGITS      = 3,
  parameter int DONE_BEEP_TICKS = 3
) (
  input  logic                clk,
  input  logic                clrn,
  input  logic [NUM_KEYS-1:0] keypad,
  input  logic                startn,
  input  logic                stopn,
  input  logic                clearn,
  input  logic                door_closed,
  input  logic                timer_zero,
  output logic [DIGIT_W-1:0]  load_data,
  output logic                loadn,
  output logic                timer_clrn,
  output logic                timer_en,
  output logic                tick_1hz,
  output logic                mag,
  output logic                beep,
  output logic [2:0]          state
);

  localparam int DCNT_W = $clog2(MAX_DIGITS + 1);
  localparam int BCNT_W = $clog2(DONE_BEEP_TICKS + 1);

  state_t              r_state;
  logic [DCNT_W-1:0]   r_digit_cnt;
  logic [BCNT_W-1:0]   r_beep_cnt;
  logic [DIGIT_W-1:0]  r_load_data;
  logic                r_loadn;
  logic                r_timer_clrn;
  logic                r_timer_en;
  logic                r_beep;

  logic                r_startn_d;
  logic                r_stopn_d;
  logic                r_clearn_d;
  logic [NUM_KEYS-1:0] r_keypad_d;

  logic                w_start_ev;
  logic                w_stop_ev;
  logic                w_clear_ev;
  logic                w_key_ev;
  logic [DIGIT_W-1:0]  w_key_digit;
  logic                w_go_cook;
  logic                w_go_done;
  logic                w_div_en;
  logic                w_div_restart;
  logic                w_wrap;
  logic                w_tick;

  // Previous-cycle copies of the buttons and keypad for edge detection.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_startn_d <= 1'b1;
      r_stopn_d  <= 1'b1;
      r_clearn_d <= 1'b1;
      r_keypad_d <= '0;
    end else begin
      r_startn_d <= startn;
      r_stopn_d  <= stopn;
      r_clearn_d <= clearn;
      r_keypad_d <= keypad;
    end
  end

  assign w_start_ev  = r_startn_d & ~startn;
  assign w_stop_ev   = r_stopn_d & ~stopn;
  assign w_clear_ev  = r_clearn_d & ~clearn;
  // A key counts only when coming from all-released; chords are never accepted.
  assign w_key_ev    = (r_keypad_d == '0) && $onehot(keypad);
  assign w_key_digit = onehot_to_bcd(keypad);

  // Transitions that restart the divider are decoded here so the divider
  // sees them in the same cycle the FSM takes them.
  assign w_go_cook = (((r_state == ST_ENTRY) && !timer_zero) || (r_state == ST_PAUSE))
                     && door_closed && w_start_ev && !w_stop_ev && !w_clear_ev;
  assign w_go_done = (r_state == ST_COOK) && door_closed && timer_zero;

  assign w_div_en      = (r_state == ST_COOK) || (r_state == ST_DONE);
  assign w_div_restart = w_go_cook | w_go_done;

  mw_tick_div #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_div (
    .clk       (clk),
    .clrn      (clrn),
    .i_restart (w_div_restart),
    .i_en      (w_div_en),
    .o_wrap    (w_wrap),
    .o_tick    (w_tick)
  );

  // Cook-sequence FSM with its registered strobes and levels.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state      <= ST_IDLE;
      r_digit_cnt  <= '0;
      r_beep_cnt   <= '0;
      r_load_data  <= '0;
      r_loadn      <= 1'b1;
      r_timer_clrn <= 1'b1;
      r_timer_en   <= 1'b0;
      r_beep       <= 1'b0;
    end else begin
      r_loadn      <= 1'b1;
      r_timer_clrn <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (w_clear_ev) begin
            r_timer_clrn <= 1'b0;
            r_digit_cnt  <= '0;
          end else if (w_key_ev) begin
            r_load_data <= w_key_digit;
            r_loadn     <= 1'b0;
            r_digit_cnt <= DCNT_W'(1);
            r_state     <= ST_ENTRY;
          end
        end
        ST_ENTRY: begin
          if (w_stop_ev || w_clear_ev) begin
            r_timer_clrn <= 1'b0;
            r_digit_cnt  <= '0;
            r_state      <= ST_IDLE;
          end else if (w_go_cook) begin
            r_timer_en <= 1'b1;
            r_state    <= ST_COOK;
          end else if (w_key_ev && (r_digit_cnt < DCNT_W'(MAX_DIGITS))) begin
            r_load_data <= w_key_digit;
            r_loadn     <= 1'b0;
            r_digit_cnt <= r_digit_cnt + DCNT_W'(1);
          end
        end
        ST_COOK: begin
          // Door open outranks everything, then timer expiry, then stop.
          if (!door_closed) begin
            r_timer_en <= 1'b0;
            r_state    <= ST_PAUSE;
          end else if (w_go_done) begin
            r_timer_en <= 1'b0;
            r_beep     <= 1'b1;
            r_beep_cnt <= '0;
            r_state    <= ST_DONE;
          end else if (w_stop_ev) begin
            r_timer_en <= 1'b0;
            r_state    <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (w_stop_ev || w_clear_ev) begin
            r_timer_clrn <= 1'b0;
            r_digit_cnt  <= '0;
            r_state      <= ST_IDLE;
          end else if (w_go_cook) begin
            r_timer_en <= 1'b1;
            r_state    <= ST_COOK;
          end
        end
        ST_DONE: begin
          if (w_stop_ev || w_clear_ev) begin
            r_timer_clrn <= 1'b0;
            r_digit_cnt  <= '0;
            r_beep       <= 1'b0;
            r_state      <= ST_IDLE;
          end else if (w_wrap) begin
            if (r_beep_cnt == BCNT_W'(DONE_BEEP_TICKS - 1)) begin
              r_beep  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_beep_cnt <= r_beep_cnt + BCNT_W'(1);
            end
          end
        end
        default: begin
          r_timer_en <= 1'b0;
          r_beep     <= 1'b0;
          r_state    <= ST_IDLE;
        end
      endcase
    end
  end

  // The magnetron follows the door with no register delay for safety.
  assign mag        = (r_state == ST_COOK) & door_closed;
  assign tick_1hz   = w_tick & w_div_en;
  assign load_data  = r_load_data;
  assign loadn      = r_loadn;
  assign timer_clrn = r_timer_clrn;
  assign timer_en   = r_timer_en;
  assign beep       = r_beep;
  assign state      = r_state;

endmodule
